// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Expected parity bit for up to 9 data bits (zero-extend narrower words)
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Receive FIFO with first-word fall-through head; reads 0 when empty.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= wdata;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_do_pop) r_rd <= r_rd + AW'(1);
            if (w_do_push && !w_do_pop) r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    assign rdata = empty ? '0 : r_mem[r_rd];
    assign count = r_count;

endmodule

// File: rtl/uart_rcv_fifo.sv
// UART receiver: synchroniser, framing FSM, bit timer and shifter feeding a FIFO.
import uart_rx_pkg::*;

module uart_rcv_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          serial_in,
    input  logic                          data_read,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun_error,
    output logic                          framing_error,
    output logic                          parity_error
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_stop;
    logic                 r_commit;
    logic                 r_fe;
    logic                 r_pe;
    logic                 r_ov;
    logic                 w_fall;
    logic                 w_sample;
    logic                 w_par_err;
    logic                 w_good;
    logic                 w_full;
    logic                 w_empty;

    assign w_fall = r_prev & ~r_sync2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_sample = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fall) w_next = START;
            end
            START: begin
                w_sample = (r_timer == HALF_M1);
                if (w_sample) w_next = r_sync2 ? IDLE : DATA;
            end
            DATA: begin
                w_sample = (r_timer == FULL_M1);
                if (w_sample && r_bitcnt == LAST_BIT)
                    w_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                w_sample = (r_timer == FULL_M1);
                if (w_sample) w_next = STOP;
            end
            STOP: begin
                w_sample = (r_timer == FULL_M1);
                if (w_sample) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_stop   <= 1'b0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (r_state == IDLE || w_sample) r_timer <= '0;
            else                             r_timer <= r_timer + TW'(1);
            if (r_state == START) r_bitcnt <= '0;
            if (w_sample) begin
                unique case (r_state)
                    DATA: begin
                        r_shift  <= {r_sync2, r_shift[DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + BW'(1);
                    end
                    PARITY: r_par <= r_sync2;
                    STOP: begin
                        r_stop   <= r_sync2;
                        r_commit <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_par_err = (PARITY_EN != 0) &&
                       (r_par != parity_bit(9'(r_shift), 1'(PARITY_ODD)));
    assign w_good    = r_commit & r_stop & ~w_par_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fe <= 1'b0;
            r_pe <= 1'b0;
            r_ov <= 1'b0;
        end else begin
            if (r_state == IDLE && w_next == START) begin
                r_fe <= 1'b0;
                r_pe <= 1'b0;
            end
            if (r_commit && !r_stop) r_fe <= 1'b1;
            if (r_commit && r_stop && w_par_err) r_pe <= 1'b1;
            if (data_read && !w_empty)                 r_ov <= 1'b0;
            else if (w_good && w_full && !data_read)   r_ov <= 1'b1;
        end
    end

    rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (w_good),
        .pop   (data_read),
        .wdata (r_shift),
        .rdata (rx_data),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign data_ready    = ~w_empty;
    assign overrun_error = r_ov;
    assign framing_error = r_fe;
    assign parity_error  = r_pe;

endmodule

// File: doc/uart_rcv_fifo.md
# uart_rcv_fifo

Parametrised UART receiver, the successor to the fixed 8N1 receive block. It adds configurable data width, bit period and optional parity, and replaces the single-entry data buffer with a FIFO. It sits between the asynchronous `serial_in` pin and the host-side read logic, delivering framed characters with per-frame error flags.

## Interface
Parameters:
- DATA_BITS, 8, character width; legal range 5–9.
- CLKS_PER_BIT, 10, clock cycles per bit; must be at least 4.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; the only clock.
- n_rst  in  1  asynchronous, active-low reset.
- serial_in  in  1  asynchronous serial line; idles high.
- data_read  in  1  pop the FIFO head this cycle.
- rx_data  out  DATA_BITS  FIFO head (first-word fall-through); 0 when empty.
- data_ready  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overrun_error  out  1  a good frame was dropped because the FIFO was full.
- framing_error  out  1  the last frame had a stop bit of 0.
- parity_error  out  1  the last frame failed the parity check.

## Operation
- serial_in passes through a 2-flop synchroniser. Both flops reset to 1, so reset does not create a false start.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on the synchronised line (previous 1, current 0) moves the FSM to START, clears the bit timer, and clears framing_error and parity_error.
  - START: re-sample the line after CLKS_PER_BIT/2 cycles (integer division).
    - Line high: false start, return to IDLE with no flag changes.
    - Line low: go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, DATA_BITS samples, LSB first, into the shift register.
  - After DATA: go to PARITY if PARITY_EN = 1, otherwise go to STOP.
  - PARITY: one sample. The error condition is XOR(data, parity bit) ≠ PARITY_ODD.
  - STOP: one sample, then return to IDLE in the next cycle. There is no wait for the full stop bit, so back-to-back frames are accepted.
- Frame commit happens in the cycle after the stop sample:
  - Stop bit 0: set framing_error, discard the data.
  - Stop bit 1 with a parity error: set parity_error, discard the data.
  - Stop bit 1, no parity error, FIFO not full: push the data.
  - Stop bit 1, no parity error, FIFO full and data_read low: discard the data and set overrun_error.
  - Stop bit 1, no parity error, FIFO full and data_read high: push and pop in the same cycle; no overrun.
- overrun_error stays set until a pop is accepted (data_read high while fifo_count > 0).
- framing_error and parity_error stay set until the next accepted start.
- data_read while the FIFO is empty is ignored; count and pointers do not change.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- Asserting reset mid-frame aborts the frame and empties the FIFO.

## Timing
- Reset values:
  - rx_data = 0, data_ready = 0, fifo_count = 0.
  - All three error flags = 0.
  - FSM in IDLE.
- Start detect: 3 cycles after the falling edge on serial_in (2 synchroniser stages plus the edge register).
- First data sample: CLKS_PER_BIT/2 + CLKS_PER_BIT cycles after the FSM enters START.
- Commit: 1 cycle after the stop sample. data_ready, fifo_count and the error flags update at the clock edge that ends the commit cycle.
- Pop: rx_data and fifo_count update at the clock edge that samples data_read high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package uart_rx_pkg holds:
  - the state enum rx_state_t (IDLE, START, DATA, PARITY, STOP);
  - a function that computes the parity bit.
- Sub-module rx_fifo: parametrised by width and depth; ports push, pop, wdata, rdata, count, full, empty.
- The top level contains the synchroniser, FSM, bit timer, bit counter and shift register.

## Test plan
- Defaults: send 0xA5 as 8N1 at 10 clocks/bit → data_ready = 1, rx_data = 0xA5, fifo_count = 1, no error flags. Pulse data_read → data_ready = 0, rx_data = 0.
- Stop bit driven 0 on frame 0x3C → framing_error = 1, fifo_count unchanged. Next good frame 0x11 → framing_error clears at its start; 0x11 is pushed.
- PARITY_EN = 1, PARITY_ODD = 0, frame 0x07 with parity bit 0 → parity_error = 1, no push. Same frame with parity bit 1 → pushed.
- FIFO_DEPTH = 4, five back-to-back frames 0x01–0x05, no reads → fifo_count = 4, overrun_error = 1. Reads return 0x01–0x04; overrun_error clears on the first pop.
- Line low for 3 cycles then high → no frame, no flags, FSM returns to IDLE.
- Assert n_rst in the middle of frame DATA with the FIFO holding 2 entries → all outputs 0, fifo_count = 0. The next full frame is received correctly.
